// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity encodings,
// FSM state type, legal parameter ranges and the bit-period calculation.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic int calc_bit_period(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO feeding the UART transmitter; only instantiated
// when UART_TX_FIFO_EN is defined. Pushes while full and pops while empty are ignored.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  // Storage array; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter (LSB first, idle-high line) with valid/ready input.
// Define UART_TX_FIFO_EN to insert a FIFO_DEPTH-entry transmit FIFO before the FSM.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 12_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_BITS-1:0]          s_data,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BIT_PERIOD = calc_bit_period(CLK_FREQ, BAUD_RATE);
  localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(BIT_PERIOD - 2);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  if (BIT_PERIOD < 2) begin : g_err_bit_period
    $error("uart_tx_param: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_err_data_bits
    $error("uart_tx_param: DATA_BITS out of range 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_err_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_err_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_fifo_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
  end

  tx_state_e             state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         bit_idx;
  logic                  stop_idx;
  logic [DATA_BITS-1:0]  shreg;
  logic                  par_bit;
  logic [DATA_BITS-1:0]  next_word;
  logic                  word_avail;
  logic                  stop_end;
  logic                  take;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] w);
    if (PARITY == PAR_ODD) return ~^w;
    else                   return ^w;
  endfunction

  assign stop_end = (state == ST_STOP) && (cnt == CNT_LAST) && (stop_idx == STOP_LAST);
  assign take     = word_avail && ((state == ST_IDLE) || stop_end);
  assign busy     = (state != ST_IDLE) || (fifo_level != '0);

`ifdef UART_TX_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid && s_ready),
    .wdata (s_data),
    .pop   (take),
    .rdata (next_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign s_ready    = !fifo_full && !rst;
  assign word_avail = !fifo_empty;
`else
  // Without the FIFO the FSM takes the word straight off the handshake.
  assign s_ready    = (state == ST_IDLE) && !rst;
  assign word_avail = s_valid && s_ready;
  assign next_word  = s_data;
  assign fifo_level = '0;
`endif

  // Frame sequencer: every line bit holds tx for BIT_PERIOD clocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      // Raised one clock early so the pulse lands on the final stop clock.
      tx_done <= (state == ST_STOP) && (stop_idx == STOP_LAST) && (cnt == CNT_PRE);
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          tx  <= 1'b1;
          if (take) begin
            shreg   <= next_word;
            par_bit <= calc_parity(next_word);
            tx      <= 1'b0;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= ST_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_idx == IDX_LAST) begin
              stop_idx <= 1'b0;
              if (PARITY != PAR_NONE) begin
                tx    <= par_bit;
                state <= ST_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= ST_STOP;
              end
            end else begin
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
              bit_idx <= bit_idx + IW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            stop_idx <= 1'b0;
            tx       <= 1'b1;
            state    <= ST_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (stop_idx != STOP_LAST) begin
              stop_idx <= stop_idx + 1'b1;
            end else if (take) begin
              shreg   <= next_word;
              par_bit <= calc_parity(next_word);
              tx      <= 1'b0;
              state   <= ST_START;
            end else begin
              tx    <= 1'b1;
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param with three configurations at BIT_PERIOD=10;
// honours UART_TX_FIFO_EN for the latency and streaming expectations.
module tb_uart_tx_param;

`ifdef UART_TX_FIFO_EN
  localparam int LAT = 2;
  localparam int GAP = 0;
  localparam int N_STREAM = 6;
`else
  localparam int LAT = 1;
  localparam int GAP = 1;
  localparam int N_STREAM = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic a_valid = 1'b0, a_ready, a_tx, a_busy, a_done;
  logic [7:0] a_data = 8'h00;
  logic [2:0] a_level;
  logic b_valid = 1'b0, b_ready, b_tx, b_busy, b_done;
  logic [6:0] b_data = 7'h00;
  logic [4:0] b_level;
  logic c_valid = 1'b0, c_ready, c_tx, c_busy, c_done;
  logic [7:0] c_data = 8'h00;
  logic [4:0] c_level;

  int sel = 0;
  logic mon_tx, mon_done, mon_ready, mon_busy;

  int n_checks = 0;
  int n_fails = 0;
  int a_done_cnt = 0;

  logic [7:0] stream_words [6] = '{8'h12, 8'hC3, 8'h7E, 8'h01, 8'hA5, 8'hF0};
  logic [7:0] rx_q [$];
  int drv_idx, drv_cyc, drv_bad, max_level, saw_not_ready, rx_idle, done_base, low_cnt;
  logic hs;
  logic [7:0] rx_word;

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst(rst), .s_valid(a_valid), .s_ready(a_ready), .s_data(a_data),
    .tx(a_tx), .busy(a_busy), .tx_done(a_done), .fifo_level(a_level));

  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                  .PARITY(2), .STOP_BITS(2)) u_7e2 (
    .clk(clk), .rst(rst), .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data),
    .tx(b_tx), .busy(b_busy), .tx_done(b_done), .fifo_level(b_level));

  uart_tx_param #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                  .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .s_valid(c_valid), .s_ready(c_ready), .s_data(c_data),
    .tx(c_tx), .busy(c_busy), .tx_done(c_done), .fifo_level(c_level));

  always_comb begin
    mon_tx = a_tx; mon_done = a_done; mon_ready = a_ready; mon_busy = a_busy;
    case (sel)
      1: begin mon_tx = b_tx; mon_done = b_done; mon_ready = b_ready; mon_busy = b_busy; end
      2: begin mon_tx = c_tx; mon_done = c_done; mon_ready = c_ready; mon_busy = c_busy; end
      default: ;
    endcase
  end

  always @(negedge clk) if (a_done) a_done_cnt <= a_done_cnt + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_word(input int s, input logic [8:0] w);
    @(negedge clk);
    sel = s;
    case (s)
      1:       begin b_valid = 1'b1; b_data = w[6:0]; end
      2:       begin c_valid = 1'b1; c_data = w[7:0]; end
      default: begin a_valid = 1'b1; a_data = w[7:0]; end
    endcase
    #1;
    check_eq("s_ready before transfer", mon_ready, 1);
    @(posedge clk);
    #1;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
  endtask

  // Called right after the transfer edge; walks every clock of the frame.
  task automatic check_frame(input string tag, input logic [8:0] w, input int nbits,
                             input int par, input int nstop);
    logic [15:0] eb;
    logic p;
    int nb;
    eb = '0; p = 1'b0; nb = 1;
    for (int i = 0; i < nbits; i++) begin eb[nb] = w[i]; p ^= w[i]; nb++; end
    if (par != 0) begin eb[nb] = (par == 1) ? ~p : p; nb++; end
    for (int i = 0; i < nstop; i++) begin eb[nb] = 1'b1; nb++; end
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      check_eq($sformatf("%s tx before start", tag), mon_tx, 1);
    end
    for (int k = 0; k < nb * 10; k++) begin
      @(negedge clk);
      check_eq($sformatf("%s tx cycle %0d", tag, k + 1), mon_tx, eb[k / 10]);
      check_eq($sformatf("%s tx_done cycle %0d", tag, k + 1), mon_done, (k == nb * 10 - 1));
    end
    @(negedge clk);
    check_eq($sformatf("%s tx idle after", tag), mon_tx, 1);
    check_eq($sformatf("%s tx_done after", tag), mon_done, 0);
    check_eq($sformatf("%s busy after", tag), mon_busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset tx", a_tx, 1);
    check_eq("reset tx_done", a_done, 0);
    check_eq("reset busy", a_busy, 0);
    check_eq("reset fifo_level", a_level, 0);
    check_eq("reset s_ready", a_ready, 0);
    check_eq("reset tx 7e2", b_tx, 1);
    rst = 1'b0;
    #1;
    check_eq("s_ready after reset", a_ready, 1);

    start_word(0, 9'h055); check_frame("8n1 55", 9'h055, 8, 0, 1);
    start_word(1, 9'h041); check_frame("7e2 41", 9'h041, 7, 2, 2);
    start_word(2, 9'h000); check_frame("8o1 00", 9'h000, 8, 1, 1);
    start_word(2, 9'h0FF); check_frame("8o1 ff", 9'h0FF, 8, 1, 1);
    start_word(0, 9'h0A3); check_frame("8n1 a3", 9'h0A3, 8, 0, 1);

    // Abort a frame during data bit 3 (cycles N+41..N+50).
    start_word(0, 9'h0A5);
`ifdef UART_TX_FIFO_EN
    repeat (20) @(negedge clk);
    a_valid = 1'b1; a_data = 8'h11;
    @(negedge clk); a_data = 8'h22;
    @(negedge clk); a_valid = 1'b0;
    repeat (23) @(negedge clk);
    check_eq("fifo_level before abort", a_level, 2);
`else
    repeat (45) @(negedge clk);
`endif
    check_eq("tx in data bit 3", a_tx, 0);
    done_base = a_done_cnt;
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort tx high", a_tx, 1);
    check_eq("abort fifo_level", a_level, 0);
    check_eq("abort busy", a_busy, 0);
    check_eq("abort s_ready in rst", a_ready, 0);
    rst = 1'b0;
    low_cnt = 0;
    repeat (40) begin @(negedge clk); if (a_tx !== 1'b1) low_cnt++; end
    check_eq("no line activity after abort", low_cnt, 0);
    check_eq("no tx_done after abort", a_done_cnt - done_base, 0);
    start_word(0, 9'h03C); check_frame("8n1 after abort", 9'h03C, 8, 0, 1);

    // Streaming with s_valid held high.
    done_base = a_done_cnt;
    drv_bad = 0; max_level = 0; saw_not_ready = 0;
    fork
      begin
        drv_idx = 0; drv_cyc = 0;
        @(negedge clk);
        a_data = stream_words[0]; a_valid = 1'b1;
        #1;
        while (drv_idx < N_STREAM && drv_cyc < 5000) begin
`ifdef UART_TX_FIFO_EN
          if (a_ready !== (a_level != 3'd4)) drv_bad++;
          if (int'(a_level) > max_level) max_level = int'(a_level);
          if (!a_ready) saw_not_ready = 1;
`else
          if (a_busy && a_ready) drv_bad++;
`endif
          hs = a_valid && a_ready;
          @(posedge clk); #1;
          if (hs) begin
            drv_idx++;
            if (drv_idx < N_STREAM) a_data = stream_words[drv_idx];
            else a_valid = 1'b0;
          end
          @(negedge clk); drv_cyc++;
        end
        a_valid = 1'b0;
        check_eq("stream driver sent all", drv_idx, N_STREAM);
      end
      begin
        for (int f = 0; f < N_STREAM; f++) begin
          @(negedge clk);
          rx_idle = 0;
          while (a_tx === 1'b1 && rx_idle < 3000) begin rx_idle++; @(negedge clk); end
          if (a_tx !== 1'b0) begin
            check_eq("stream start bit timeout", a_tx, 0);
            break;
          end
          if (f > 0) check_eq($sformatf("stream gap before frame %0d", f), rx_idle, GAP);
          rx_word = 8'h00;
          repeat (15) @(negedge clk);
          rx_word[0] = a_tx;
          for (int i = 1; i < 8; i++) begin repeat (10) @(negedge clk); rx_word[i] = a_tx; end
          repeat (10) @(negedge clk);
          check_eq($sformatf("stream stop bit %0d", f), a_tx, 1);
          repeat (4) @(negedge clk);
          check_eq($sformatf("stream tx_done %0d", f), a_done, 1);
          rx_q.push_back(rx_word);
        end
      end
    join
    repeat (3) @(negedge clk);
    check_eq("stream handshake rule", drv_bad, 0);
`ifdef UART_TX_FIFO_EN
    check_eq("stream max fifo_level", max_level, 4);
    check_eq("stream s_ready dropped", saw_not_ready, 1);
`endif
    check_eq("stream tx_done count", a_done_cnt - done_base, N_STREAM);
    check_eq("stream word count", rx_q.size(), N_STREAM);
    for (int i = 0; i < N_STREAM && i < rx_q.size(); i++)
      check_eq($sformatf("stream word %0d", i), rx_q[i], stream_words[i]);
    check_eq("stream busy at end", a_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
